// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// bounded hold timer that forcibly revokes long-running ownerships.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam logic       HOLD_EN  = (HOLD_MAX != 0);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       w_pick_vld;
  logic [1:0] w_pick_idx;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // Rotating-priority pick: scan from the far end so the slot nearest ptr wins.
  always_comb begin
    logic [1:0] w_scan;
    w_pick_vld = 1'b0;
    w_pick_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_scan     = r_ptr + 2'(k);
      w_pick_vld = w_pick_vld | req[w_scan];
      w_pick_idx = req[w_scan] ? w_scan : w_pick_idx;
    end
  end

  // Next-state logic: release beats preempt, preempt beats hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (En && w_pick_vld) begin
          w_owner_nxt = w_pick_idx;
          w_gnt_nxt   = onehot4(w_pick_idx);
          w_cnt_nxt   = 8'd1;
          w_state_nxt = ST_GRANT;
        end else begin
          w_gnt_nxt   = 4'b0000;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[r_owner]) begin
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_owner + 2'd1;
          w_state_nxt = ST_IDLE;
        end else if (HOLD_EN && (r_cnt == HOLD_LIM)) begin
          w_gnt_nxt     = 4'b0000;
          w_ptr_nxt     = r_owner + 2'd1;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          // Saturate so a disabled limit never wraps back into range.
          w_cnt_nxt = (r_cnt != 8'hFF) ? (r_cnt + 8'd1) : r_cnt;
        end
      end
      default: begin
        w_gnt_nxt   = 4'b0000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_cnt     <= 8'd0;
      r_gnt     <= 4'b0000;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign busy    = (r_gnt != 4'b0000);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench: two arbiters (hold limit 4 and limit disabled) driven with
// directed and random traffic, checked against a high-level ownership model.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, to_a, to_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] ga;
    logic       ta;
    logic [3:0] gb;
    logic       tb;
  } exp_t;

  exp_t exp_q[$];

  // model state per DUT: 0 -> HOLD_MAX=4, 1 -> HOLD_MAX=0
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_to[2];
  int m_hold[2] = '{4, 0};

  rr_arbiter4 #(.HOLD_MAX(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .En(En), .req(req),
    .gnt(gnt_a), .busy(busy_a), .timeout(to_a)
  );

  rr_arbiter4 #(.HOLD_MAX(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .En(En), .req(req),
    .gnt(gnt_b), .busy(busy_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_ptr[d]   = 0;
      m_to[d]    = 0;
    end
  endtask

  task automatic model_step(input int d, input logic en, input logic [3:0] r);
    m_to[d] = 0;
    if (m_owner[d] < 0) begin
      if (en && r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 4]) begin
            m_owner[d] = (m_ptr[d] + k) % 4;
            m_held[d]  = 1;
          end
        end
      end
    end else if (!r[m_owner[d]]) begin
      m_ptr[d]   = (m_owner[d] + 1) % 4;
      m_owner[d] = -1;
    end else if (m_hold[d] != 0 && m_held[d] == m_hold[d]) begin
      m_ptr[d]   = (m_owner[d] + 1) % 4;
      m_owner[d] = -1;
      m_to[d]    = 1;
    end else if (m_held[d] < 255) begin
      m_held[d]++;
    end
  endtask

  function automatic logic [3:0] m_gnt(input int d);
    return (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
  endfunction

  // One clock of stimulus: drive away from the edge, step the model on the edge.
  task automatic cycle(input logic en, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    En  = en;
    req = r;
    @(posedge clk);
    model_step(0, en, r);
    model_step(1, en, r);
    e.ga = m_gnt(0);
    e.ta = 1'(m_to[0]);
    e.gb = m_gnt(1);
    e.tb = 1'(m_to[1]);
    exp_q.push_back(e);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    En    = 1'b0;
    req   = 4'b0000;
    #1;
    chk("rst_gnt_a", 32'(gnt_a), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_to_a", 32'(to_a), 32'h0);
    chk("rst_gnt_b", 32'(gnt_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops one expectation per edge and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt_a", 32'(gnt_a), 32'(e.ga));
        chk("busy_a", 32'(busy_a), 32'(e.ga != 4'b0000));
        chk("timeout_a", 32'(to_a), 32'(e.ta));
        chk("gnt_b", 32'(gnt_b), 32'(e.gb));
        chk("busy_b", 32'(busy_b), 32'(e.gb != 4'b0000));
        chk("timeout_b", 32'(to_b), 32'(e.tb));
      end
    end
  end

  initial begin
    logic [3:0] order[5];
    logic [3:0] r;
    logic       en;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    rst_n = 1'b0;
    En    = 1'b0;
    req   = 4'b0000;
    model_reset();
    #1;
    chk("init_gnt", 32'(gnt_a), 32'h0);
    chk("init_timeout", 32'(to_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin rotation, each owner drops its own bit after 2 cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b1111);
      #1;
      chk("rr_order", 32'(gnt_a), 32'(order[i]));
      cycle(1'b1, 4'b1111);
      cycle(1'b1, 4'b1111 & ~4'(1 << m_owner[0]));
    end

    // timeout with two constant requesters
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'b0011);
    cycle(1'b1, 4'b0000);

    // enable gating
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010);
    cycle(1'b1, 4'b0010);
    #1;
    chk("en_grant", 32'(gnt_a), 32'h2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0000);

    // release and limit on the same edge: release wins, no timeout
    cycle(1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b1111);
    #1;
    chk("collide_next", 32'(gnt_a), 32'h8);
    cycle(1'b1, 4'b0000);

    // non-owner noise while requester 1 owns
    cycle(1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(($urandom & 32'hD)) | 4'b0010);
    cycle(1'b1, 4'b0000);

    // reset mid-grant, then first grant from a fresh pointer
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0100);
    async_reset();
    cycle(1'b1, 4'b1111);
    #1;
    chk("post_rst_grant", 32'(gnt_a), 32'h1);

    // randomized traffic, owner mostly keeps requesting
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      r  = 4'($urandom);
      if (m_owner[0] >= 0 && $urandom_range(0, 5) != 0) r[m_owner[0]] = 1'b1;
      if (m_owner[1] >= 0 && $urandom_range(0, 7) != 0) r[m_owner[1]] = 1'b1;
      cycle(en, r);
      if (i == 700) async_reset();
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with a bounded grant-hold timer. It registers a one-hot grant vector that feeds directly into the one-hot-to-binary encoder stage, so the encoder sees exactly one hot bit while a grant is active and all-zero otherwise. The grant is held while the owner keeps requesting, up to a programmable limit. Fairness comes from a rotating priority pointer.

## Interface
- HOLD_MAX, default 16: maximum consecutive grant cycles per ownership. Legal range is 0..255. 0 disables the timeout.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- En  in  1  arbitration enable; gates new grants only
- req  in  4  request lines; req[i] high = requester i wants ownership
- gnt  out  4  registered one-hot grant; 4'b0000 when no owner
- busy  out  1  high while gnt != 0
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- Internal state:
  - FSM: IDLE, GRANT.
  - ptr[1:0]: highest-priority index.
  - owner[1:0].
  - cnt[7:0].
- Reset (asynchronous, rst_n low): state=IDLE, ptr=0, owner=0, cnt=0, gnt=4'b0000, busy=0, timeout=0. Reset takes effect immediately, including mid-grant. Operation resumes on the first rising edge after rst_n rises.
- IDLE, when En=1 and req!=0:
  - Select the first asserted req[i] scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - owner=i, gnt=1<<i, cnt=1, go to GRANT.
- IDLE, otherwise: stay in IDLE with gnt=0.
- GRANT, evaluated in priority order at each edge:
  1. Release: if req[owner]=0, then gnt=0, ptr=owner+1 (mod 4), go to IDLE.
  2. Preempt: else if HOLD_MAX!=0 and cnt==HOLD_MAX, then gnt=0, ptr=owner+1 (mod 4), timeout=1 for the next cycle, go to IDLE.
  3. Hold: else cnt=cnt+1, gnt unchanged.
- En=0 during GRANT does not revoke the grant. It only blocks the next grant from IDLE.
- Requests from non-owners during GRANT are ignored. They are arbitrated at the next IDLE evaluation.
- gnt is always one-hot or zero. It never carries more than one set bit.
- busy is combinationally equal to (gnt != 0), i.e. it follows the registered state.

## Timing
- Grant latency: a req sampled high in IDLE with En=1 produces gnt on the same edge. gnt is visible 1 cycle after req is presented.
- Release latency: when req[owner] is sampled low, gnt goes to 0 on that edge.
- Mandatory gap: at least one IDLE cycle (gnt=0) separates any two grants, including back-to-back grants to different requesters. The downstream encoder therefore sees its default code between owners.
- Maximum hold: with req[owner] held high, gnt stays asserted for exactly HOLD_MAX cycles. timeout is high in the cycle immediately after gnt drops.
- Simultaneous release and timeout on the same edge: release wins and timeout stays 0.
- HOLD_MAX=0: cnt still increments and saturates at 255 (no wrap). Preempt never fires.
- Pointer rotation: after owner 3 is released, ptr wraps to 0.
- Worst-case wait for a continuously requesting input with HOLD_MAX=H: 3*(H+1) cycles after it is sampled.

## Test plan
- Reset mid-grant: grant req=4'b0100, then pull rst_n low asynchronously between edges. gnt=0, busy=0 and timeout=0 immediately. After rst_n rises, the first grant with req=4'b1111 is gnt=4'b0001.
- Round-robin rotation: En=1, req=4'b1111 held. Each owner releases after 2 cycles by dropping only its own bit for 1 cycle. Grant order is 0001, 0010, 0100, 1000, 0001, with one gnt=0 cycle between grants.
- Timeout: HOLD_MAX=4, req=4'b0011 held constantly. gnt=0001 for 4 cycles, then 0000 with timeout=1 for 1 cycle, then gnt=0010 for 4 cycles.
- Enable gating: En=0, req=4'b0010 gives gnt stays 0. Raise En to 1, and gnt=0010 after 1 edge. Drop En to 0 mid-grant, and gnt remains 0010 until req[1] falls.
- Release/timeout collision: HOLD_MAX=3, req[2] dropped on the edge where cnt==3. gnt goes to 0, timeout=0, ptr=3, so the next grant with req=4'b1111 is 1000.
- Non-owner noise: owner=1. Toggling req[0], req[2] and req[3] arbitrarily leaves gnt steady at 0010 and busy=1 until req[1]=0.
